point_sequencer: RTL and testbench
==================================

POINT_SEQUENCER -- requirements
Module: point_sequencer

Interface
REQ-001 Parameters: index_bits, default 11, width of point index and count; step, default 16, maximum per-axis move per DAC sample (1..2047).
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 drawing  input  1  frame buffer holds a frame to draw (from frame buffer block).
REQ-005 num_points  input  index_bits  point count of readable buffer.
REQ-006 point  input  25  RAM word: [24] beam on, [23:12] x, [11:0] y; valid one cycle after read_address.
REQ-007 read_address  output  index_bits  registered RAM read index.
REQ-008 done_drawing  output  1  one-cycle pulse: frame finished.
REQ-009 dac_x, dac_y  output  12 each  registered sample coordinates.
REQ-010 blank  output  1  registered; 1 = beam off for this sample.
REQ-011 dac_valid  output  1  sample present; dac_ready input 1: sink accepts; transfer = dac_valid & dac_ready on a rising edge.

Function
REQ-012 FSM states: IDLE, ADDR, DATA, EMIT, DONE.
REQ-013 IDLE: drawing=1 at an edge -> latch num_points as frame count N, index<=0, read_address<=0; N=0 -> DONE, else ADDR. drawing=0 -> stay.
REQ-014 ADDR: one wait cycle for RAM latency -> DATA.
REQ-015 DATA: capture point as target (tx, ty, on), load first sample into dac_x/dac_y/blank, dac_valid<=1 -> EMIT; first dac_valid is high exactly 3 edges after IDLE sampled drawing=1.
REQ-016 Step rule, per axis independently: d = target - current (13-bit signed); |d| <= step -> next = target; else next = current + step (d>0) or current - step (d<0); result always within 0..4095.
REQ-017 blank = ~on of the segment's target point for every sample of that segment.
REQ-018 Every point emits at least one sample, including target == current position (one sample at target).
REQ-019 EMIT, no transfer: dac_x, dac_y, blank, dac_valid held unchanged.
REQ-020 EMIT, transfer, sample != target: next step sample loaded same edge, dac_valid stays 1 (one sample per cycle at full rate).
REQ-021 EMIT, transfer, sample == target, index < N-1: dac_valid<=0, index and read_address <= index+1, -> ADDR (2 idle cycles between segments).
REQ-022 EMIT, transfer, sample == target, index = N-1: dac_valid<=0, done_drawing<=1, -> DONE.
REQ-023 DONE: done_drawing high exactly one cycle; next edge done_drawing<=0 -> IDLE; IDLE does not sample drawing in the cycle done_drawing is high.
REQ-024 Drawing still high after DONE (no new frame upstream): frame redrawn from index 0; num_points re-latched.
REQ-025 drawing or num_points changing mid-frame: ignored until next IDLE.
REQ-026 Current beam position (last transferred sample) persists across frames; first segment of a frame starts from it.
REQ-027 dac_valid never asserted in IDLE, ADDR, DONE.

Reset
REQ-028 reset=1 at an edge: state IDLE, read_address 0, index 0, done_drawing 0, dac_valid 0, dac_x 0, dac_y 0, blank 1, position (0,0); overrides all other activity, including mid-segment and mid-handshake.

Verification
REQ-029 From (0,0), N=1, point {on=1,x=100,y=0}, dac_ready=1, step=16 -> samples x=16,32,48,64,80,96,100, y=0, blank=0, consecutive cycles; single done_drawing pulse.
REQ-030 Target (40,8) from (0,0) -> samples (16,8),(32,8),(40,8); then target (0,0) with on=0 -> (24,0),(8,0),(0,0), blank=1, dac_valid low 2 cycles between segments.
REQ-031 dac_ready low 5 cycles mid-segment -> dac_x/dac_y/blank/dac_valid constant throughout; sequence resumes with no sample lost or duplicated.
REQ-032 num_points=0, drawing=1 -> done_drawing pulse, dac_valid never high; drawing held high -> pulse repeats every 3 cycles.
REQ-033 drawing held high, N=2 -> full frame replayed from index 0 after each done pulse; drawing drops the cycle after the pulse -> no restart until drawing reasserts.
REQ-034 reset asserted during EMIT with dac_valid=1 -> next cycle all outputs at REQ-028 values; new frame restarts from (0,0).

Source files
------------

// File: rtl/point_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : point_sequencer
// Description : Walks a frame of points from RAM and emits DAC samples that
//               step the beam toward each point, at most STEP per axis.
// Revision    : 1.0 - initial release
// ============================================================================
module point_sequencer #(
    parameter int INDEX_BITS = 11,
    parameter int STEP       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  drawing,
    input  logic [INDEX_BITS-1:0] num_points,
    input  logic [24:0]           point,
    output logic [INDEX_BITS-1:0] read_address,
    output logic                  done_drawing,
    output logic [11:0]           dac_x,
    output logic [11:0]           dac_y,
    output logic                  blank,
    output logic                  dac_valid,
    input  logic                  dac_ready
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_DATA = 3'd2,
        S_EMIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [12:0]           c_STEP = 13'(STEP);
    localparam logic [INDEX_BITS-1:0] c_ONE  = INDEX_BITS'(1);

    // One axis of the step rule: jump to target when within STEP, else move STEP.
    function automatic logic [11:0] step_toward(input logic [11:0] cur,
                                                input logic [11:0] tgt);
        logic signed [12:0] d;
        d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (d > $signed(c_STEP))
            return cur + c_STEP[11:0];
        else if (d < -$signed(c_STEP))
            return cur - c_STEP[11:0];
        else
            return tgt;
    endfunction

    state_t                r_state;
    logic [INDEX_BITS-1:0] r_index;
    logic [INDEX_BITS-1:0] r_count;
    logic [11:0]           r_tx;
    logic [11:0]           r_ty;
    logic [11:0]           r_pos_x;
    logic [11:0]           r_pos_y;
    logic                  r_holdoff;

    logic [11:0] w_first_x;
    logic [11:0] w_first_y;
    logic [11:0] w_next_x;
    logic [11:0] w_next_y;
    logic        w_xfer;
    logic        w_at_target;
    logic        w_last_point;

    assign w_first_x    = step_toward(r_pos_x, point[23:12]);
    assign w_first_y    = step_toward(r_pos_y, point[11:0]);
    assign w_next_x     = step_toward(dac_x, r_tx);
    assign w_next_y     = step_toward(dac_y, r_ty);
    assign w_xfer       = dac_valid & dac_ready;
    assign w_at_target  = (dac_x == r_tx) && (dac_y == r_ty);
    assign w_last_point = (r_index == r_count - c_ONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_index      <= '0;
            r_count      <= '0;
            r_tx         <= '0;
            r_ty         <= '0;
            r_pos_x      <= '0;
            r_pos_y      <= '0;
            r_holdoff    <= 1'b0;
            read_address <= '0;
            done_drawing <= 1'b0;
            dac_x        <= '0;
            dac_y        <= '0;
            blank        <= 1'b1;
            dac_valid    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // The cycle right after a done pulse is skipped so the
                    // frame buffer can react before drawing is looked at again.
                    if (r_holdoff) begin
                        r_holdoff <= 1'b0;
                    end else if (drawing) begin
                        r_count      <= num_points;
                        r_index      <= '0;
                        read_address <= '0;
                        if (num_points == '0) begin
                            done_drawing <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_state <= S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    r_state <= S_DATA;
                end
                S_DATA: begin
                    r_tx      <= point[23:12];
                    r_ty      <= point[11:0];
                    dac_x     <= w_first_x;
                    dac_y     <= w_first_y;
                    blank     <= ~point[24];
                    dac_valid <= 1'b1;
                    r_state   <= S_EMIT;
                end
                S_EMIT: begin
                    if (w_xfer) begin
                        r_pos_x <= dac_x;
                        r_pos_y <= dac_y;
                        if (!w_at_target) begin
                            dac_x <= w_next_x;
                            dac_y <= w_next_y;
                        end else begin
                            dac_valid <= 1'b0;
                            if (w_last_point) begin
                                done_drawing <= 1'b1;
                                r_state      <= S_DONE;
                            end else begin
                                r_index      <= r_index + c_ONE;
                                read_address <= r_index + c_ONE;
                                r_state      <= S_ADDR;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_drawing <= 1'b0;
                    r_holdoff    <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_point_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_point_sequencer
// Description : Self-checking bench for point_sequencer against a sample-list
//               reference model built from the stepping rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_point_sequencer;

    localparam int INDEX_BITS = 11;
    localparam int STEP       = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  drawing;
    logic [INDEX_BITS-1:0] num_points;
    logic [24:0]           point;
    logic [INDEX_BITS-1:0] read_address;
    logic                  done_drawing;
    logic [11:0]           dac_x;
    logic [11:0]           dac_y;
    logic                  blank;
    logic                  dac_valid;
    logic                  dac_ready;

    int errors = 0;
    int checks = 0;

    logic [24:0] mem [0:15];
    int m_x;
    int m_y;

    typedef struct {
        int x;
        int y;
        bit blank;
        bit seg_end;
        bit frame_end;
    } sample_t;

    sample_t exp_q[$];

    point_sequencer #(
        .INDEX_BITS (INDEX_BITS),
        .STEP       (STEP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .drawing      (drawing),
        .num_points   (num_points),
        .point        (point),
        .read_address (read_address),
        .done_drawing (done_drawing),
        .dac_x        (dac_x),
        .dac_y        (dac_y),
        .blank        (blank),
        .dac_valid    (dac_valid),
        .dac_ready    (dac_ready)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM: data valid one cycle after the address.
    always @(posedge clk) point <= mem[read_address[3:0]];

    function automatic int toward(input int c, input int t);
        if (t - c > STEP) return c + STEP;
        if (c - t > STEP) return c - STEP;
        return t;
    endfunction

    // Expected sample list: every point gets at least one sample, each axis
    // moves by at most STEP, blank follows the target's beam bit.
    task automatic build(input int n, input int frames);
        logic [24:0] w;
        int tx, ty;
        sample_t s;
        for (int f = 0; f < frames; f++) begin
            for (int i = 0; i < n; i++) begin
                w  = mem[i];
                tx = int'(w[23:12]);
                ty = int'(w[11:0]);
                do begin
                    m_x = toward(m_x, tx);
                    m_y = toward(m_y, ty);
                    s.x = m_x;
                    s.y = m_y;
                    s.blank = ~w[24];
                    s.seg_end = (m_x == tx) && (m_y == ty);
                    s.frame_end = s.seg_end && (i == n - 1);
                    exp_q.push_back(s);
                end while (!s.seg_end);
            end
        end
    endtask

    task automatic drive_frames(input int n, input int frames, input int stall_at,
                                input bit rand_ready);
        int cycles = 0;
        int xfers = 0;
        int dones = 0;
        int gap = 0;
        int stall = 0;
        bit seen = 1'b0;
        bit in_gap = 1'b0;
        bit want_done = 1'b0;
        logic [11:0] hx, hy;
        logic hb;
        sample_t s;
        exp_q.delete();
        build(n, frames);
        num_points = n[INDEX_BITS-1:0];
        drawing = 1'b1;
        while (exp_q.size() > 0 || dones < frames) begin
            @(negedge clk);
            cycles++;
            if (cycles > 20000) begin
                checks++; errors++;
                $display("FAIL timeout: got %0d samples left, want 0", exp_q.size());
                break;
            end
            if (!seen && dac_valid) begin
                seen = 1'b1;
                if (!rand_ready) begin
                    checks++;
                    if (cycles !== 3) begin
                        errors++;
                        $display("FAIL first_valid_latency: got %0d edges, want 3", cycles);
                    end
                end
            end
            if (want_done) begin
                checks++;
                if (done_drawing !== 1'b1) begin
                    errors++;
                    $display("FAIL done_pulse: got %b, want 1", done_drawing);
                end
                dones++;
                want_done = 1'b0;
            end else if (done_drawing) begin
                checks++; errors++;
                $display("FAIL spurious_done: got 1, want 0");
            end
            if (in_gap) begin
                if (dac_valid) begin
                    in_gap = 1'b0;
                    checks++;
                    if (gap !== 2) begin
                        errors++;
                        $display("FAIL segment_gap: got %0d idle cycles, want 2", gap);
                    end
                end else begin
                    gap++;
                end
            end
            if (stall_at >= 0 && xfers == stall_at && stall < 5 && dac_valid) begin
                dac_ready = 1'b0;
                if (stall == 0) begin
                    hx = dac_x; hy = dac_y; hb = blank;
                end else begin
                    checks++;
                    if ({dac_valid, dac_x, dac_y, blank} !== {1'b1, hx, hy, hb}) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%b x=%0d y=%0d b=%b, want v=1 x=%0d y=%0d b=%b",
                                 dac_valid, dac_x, dac_y, blank, hx, hy, hb);
                    end
                end
                stall++;
            end else begin
                dac_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (dac_valid && dac_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_sample: got x=%0d y=%0d, want no sample", dac_x, dac_y);
                end else begin
                    s = exp_q.pop_front();
                    if (dac_x !== 12'(s.x) || dac_y !== 12'(s.y) || blank !== s.blank) begin
                        errors++;
                        $display("FAIL sample: got x=%0d y=%0d blank=%b, want x=%0d y=%0d blank=%b",
                                 dac_x, dac_y, blank, s.x, s.y, s.blank);
                    end
                    xfers++;
                    if (s.frame_end) want_done = 1'b1;
                    else if (s.seg_end) begin in_gap = 1'b1; gap = 0; end
                end
            end
        end
        drawing = 1'b0;
        dac_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (dac_valid !== 1'b0 || done_drawing !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_frame: got v=%b done=%b, want 0 0", dac_valid, done_drawing);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if (read_address !== '0 || done_drawing !== 1'b0 || dac_valid !== 1'b0 ||
            dac_x !== 12'd0 || dac_y !== 12'd0 || blank !== 1'b1) begin
            errors++;
            $display("FAIL %s: got ra=%0d done=%b v=%b x=%0d y=%0d b=%b, want 0 0 0 0 0 1",
                     tag, read_address, done_drawing, dac_valid, dac_x, dac_y, blank);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; drawing = 1'b0; num_points = '0; dac_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        reset = 1'b0;
        m_x = 0; m_y = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("idle_no_drawing");
    endtask

    task automatic test_two_segments();
        mem[0] = {1'b1, 12'd40, 12'd8};
        mem[1] = {1'b0, 12'd0, 12'd0};
        drive_frames(2, 1, -1, 1'b0);
    endtask

    task automatic test_single_run();
        mem[0] = {1'b1, 12'd100, 12'd0};
        drive_frames(1, 1, -1, 1'b0);
        checks++;
        if (dac_x !== 12'd100 || dac_y !== 12'd0 || blank !== 1'b0) begin
            errors++;
            $display("FAIL final_sample: got x=%0d y=%0d b=%b, want 100 0 0", dac_x, dac_y, blank);
        end
    endtask

    task automatic test_backpressure();
        mem[0] = {1'b1, 12'd300, 12'd50};
        drive_frames(1, 1, 4, 1'b0);
    endtask

    task automatic test_empty();
        int last = -1;
        int pulses = 0;
        int vcount = 0;
        num_points = '0;
        drawing = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (dac_valid) vcount++;
            if (done_drawing) begin
                pulses++;
                if (last >= 0) begin
                    checks++;
                    if (c - last !== 3) begin
                        errors++;
                        $display("FAIL empty_period: got %0d cycles, want 3", c - last);
                    end
                end
                last = c;
            end
        end
        drawing = 1'b0;
        checks++;
        if (vcount !== 0) begin
            errors++;
            $display("FAIL empty_valid: got %0d valid cycles, want 0", vcount);
        end
        checks++;
        if (pulses !== 4) begin
            errors++;
            $display("FAIL empty_pulses: got %0d, want 4", pulses);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_redraw();
        mem[0] = {1'b1, 12'd60, 12'd90};
        mem[1] = {1'b1, 12'd10, 12'd70};
        drive_frames(2, 3, -1, 1'b1);
    endtask

    function automatic logic [11:0] pick_coord();
        case ($urandom_range(0, 3))
            0: return 12'd0;
            1: return 12'd4095;
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    task automatic test_random();
        int n;
        for (int k = 0; k < 5; k++) begin
            n = $urandom_range(1, 5);
            for (int i = 0; i < n; i++)
                mem[i] = {1'($urandom_range(0, 1)), pick_coord(), pick_coord()};
            drive_frames(n, 1, -1, 1'b1);
        end
    endtask

    task automatic test_reset_mid();
        mem[0] = {1'b1, 12'd4000, 12'd3000};
        num_points = INDEX_BITS'(1);
        dac_ready = 1'b1;
        drawing = 1'b1;
        for (int c = 0; c < 20 && !dac_valid; c++) @(negedge clk);
        checks++;
        if (dac_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_valid: got %b, want 1", dac_valid);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        drawing = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_mid_emit");
        reset = 1'b0;
        m_x = 0; m_y = 0;
        mem[0] = {1'b1, 12'd20, 12'd5};
        drive_frames(1, 1, -1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = '0;
        reset = 1'b1;
        drawing = 1'b0;
        num_points = '0;
        dac_ready = 1'b1;
        m_x = 0;
        m_y = 0;
        test_reset();
        test_two_segments();
        test_single_run();
        test_backpressure();
        test_empty();
        test_redraw();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
